// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction ROM port,
// and the {pc_plus_1, insn, valid} bundle handed to the F/D latch.
interface fetch_stage_if #(
    parameter int ADDR_W = 12
);
    logic              stall;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_q;
    logic [31:0]       fd_pc_plus_1;
    logic [31:0]       fd_insn;
    logic              fd_valid;
    logic [31:0]       fetch_count;

    // The fetch stage itself
    modport master (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_q,
        output imem_addr,
        output fd_pc_plus_1,
        output fd_insn,
        output fd_valid,
        output fetch_count
    );

    // Surroundings: hazard unit, X stage, ROM and F/D latch
    modport slave (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output imem_q,
        input  imem_addr,
        input  fd_pc_plus_1,
        input  fd_insn,
        input  fd_valid,
        input  fetch_count
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the PC, addresses a synchronous ROM with one
// cycle of read latency, and presents the fetched instruction to the F/D latch.
// A stall parks the presented instruction in a one-entry hold buffer so the
// ROM word that keeps arriving behind it is not lost; a redirect from X
// squashes both the hold buffer and the in-flight fetch.
module fetch_stage #(
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] NOP      = 32'h0
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    fetch_stage_if.master io_fetch
);

    // Architectural PC: the address being presented to the ROM this cycle
    logic [31:0] r_pc;
    // PC whose ROM word is arriving on imem_q this cycle, and whether it is real
    logic [31:0] r_inflPc;
    logic        r_inflV;
    // One-entry buffer holding the instruction that was stalled at the output
    logic        r_holdV;
    logic [31:0] r_holdPc;
    logic [31:0] r_holdInsn;
    // Instructions consumed by decode since reset
    logic [31:0] r_fetchCount;

    logic        w_rawV;
    logic        w_fdValid;
    logic        w_accept;
    logic        w_advance;
    logic [31:0] w_selPc;
    logic [31:0] w_selInsn;
    logic [31:0] w_pcPlus1;

    // Pick the output source (hold buffer first) and derive the handshake terms
    always_comb begin
        w_selPc   = r_inflPc;
        w_selInsn = io_fetch.imem_q;
        if (r_holdV) begin
            w_selPc   = r_holdPc;
            w_selInsn = r_holdInsn;
        end
        w_rawV    = r_holdV | r_inflV;
        w_fdValid = w_rawV & ~io_fetch.redirect_valid;
        w_accept  = w_fdValid & ~io_fetch.stall;
        // An empty output slot never blocks the PC, even under stall
        w_advance = ~io_fetch.stall | ~w_rawV;
        w_pcPlus1 = w_selPc + 32'd1;
    end

    // Drive the F/D bundle, forcing a clean NOP/0 whenever nothing real is shown
    always_comb begin
        io_fetch.fd_valid     = w_fdValid;
        io_fetch.fd_insn      = NOP;
        io_fetch.fd_pc_plus_1 = 32'd0;
        if (w_fdValid) begin
            io_fetch.fd_insn      = w_selInsn;
            io_fetch.fd_pc_plus_1 = w_pcPlus1;
        end
    end

    assign io_fetch.imem_addr   = r_pc[ADDR_W-1:0];
    assign io_fetch.fetch_count = r_fetchCount;

    // PC, in-flight tracking and hold buffer: redirect beats advance beats stall
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pc       <= RESET_PC;
            r_inflPc   <= 32'd0;
            r_inflV    <= 1'b0;
            r_holdV    <= 1'b0;
            r_holdPc   <= 32'd0;
            r_holdInsn <= 32'd0;
        end else if (io_fetch.redirect_valid) begin
            r_pc    <= io_fetch.redirect_pc;
            r_inflV <= 1'b0;
            r_holdV <= 1'b0;
        end else if (w_advance) begin
            r_pc     <= r_pc + 32'd1;
            r_inflPc <= r_pc;
            r_inflV  <= 1'b1;
            r_holdV  <= 1'b0;
        end else begin
            r_inflPc <= r_pc;
            r_inflV  <= 1'b1;
            if (!r_holdV) begin
                r_holdPc   <= r_inflPc;
                r_holdInsn <= io_fetch.imem_q;
                r_holdV    <= 1'b1;
            end
        end
    end

    // Count every instruction actually taken by decode
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_fetchCount <= 32'd0;
        end else if (w_accept) begin
            r_fetchCount <= r_fetchCount + 32'd1;
        end
    end

endmodule
